// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl: prescaled down-counter with one-shot and auto-reload modes,
// pause/resume and abort. All outputs are registered or decoded from the state register.
module countdown_timer_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic [PW-1:0]    prescale,
  input  logic             auto_reload,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             start_ack,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [PW-1:0]    pre_cnt_q, pre_cnt_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             auto_q, auto_d;
  logic             start_ack_q, start_ack_d;
  logic             tc_q, tc_d;

  logic active;
  logic do_abort;
  logic accept;
  logic load_zero;
  logic advance;
  logic tick;
  logic last;

  // Event decode, highest priority first: abort, start acceptance, pause, tick.
  always_comb begin
    active    = (state_q == StRun) || (state_q == StPause);
    do_abort  = abort && (state_q != StIdle);
    // Abort masks start even in IDLE, where abort itself does nothing.
    accept    = start && !abort && !active;
    load_zero = (load_val == '0);
    // A PAUSE cycle with pause released already counts, so N paused cycles cost N clocks.
    advance   = active && !abort && !pause;
    tick      = advance && (pre_cnt_q == '0);
    // <= 1 rather than == 1 so a zero count can never wrap.
    last      = tick && (cnt_q <= WIDTH'(1));
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (do_abort) begin
      state_d = StIdle;
    end else if (accept) begin
      state_d = load_zero ? StDone : StRun;
    end else if (active) begin
      if (pause) begin
        state_d = StPause;
      end else if (last && !auto_q) begin
        state_d = StDone;
      end else begin
        state_d = StRun;
      end
    end
  end

  // Datapath next-state: count, prescaler, latched configuration and output pulses.
  always_comb begin
    cnt_d       = cnt_q;
    pre_cnt_d   = pre_cnt_q;
    reload_d    = reload_q;
    presc_d     = presc_q;
    auto_d      = auto_q;
    start_ack_d = 1'b0;
    tc_d        = 1'b0;
    if (do_abort) begin
      cnt_d     = '0;
      pre_cnt_d = '0;
    end else if (accept) begin
      cnt_d       = load_val;
      pre_cnt_d   = prescale;
      reload_d    = load_val;
      presc_d     = prescale;
      auto_d      = auto_reload;
      start_ack_d = 1'b1;
      // A zero load terminates immediately.
      tc_d        = load_zero;
    end else if (advance) begin
      if (tick) begin
        pre_cnt_d = presc_q;
        if (last) begin
          tc_d  = 1'b1;
          cnt_d = auto_q ? reload_q : '0;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end else begin
        pre_cnt_d = pre_cnt_q - PW'(1);
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; reset also discards the latched configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      pre_cnt_q   <= '0;
      reload_q    <= '0;
      presc_q     <= '0;
      auto_q      <= 1'b0;
      start_ack_q <= 1'b0;
      tc_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      reload_q    <= reload_d;
      presc_q     <= presc_d;
      auto_q      <= auto_d;
      start_ack_q <= start_ack_d;
      tc_q        <= tc_d;
    end
  end

  // Output decode.
  always_comb begin
    q         = cnt_q;
    start_ack = start_ack_q;
    tc        = tc_q;
    busy      = (state_q == StRun) || (state_q == StPause);
    done      = (state_q == StDone);
  end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed self-checking bench for countdown_timer_ctrl (WIDTH=4, PW=4).
module tb_countdown_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] load_val;
  logic [3:0] prescale;
  logic       auto_reload;
  logic       pause;
  logic       abort;
  logic [3:0] q;
  logic       start_ack;
  logic       tc;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  countdown_timer_ctrl #(
    .WIDTH(4),
    .PW   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load_val   (load_val),
    .prescale   (prescale),
    .auto_reload(auto_reload),
    .pause      (pause),
    .abort      (abort),
    .q          (q),
    .start_ack  (start_ack),
    .tc         (tc),
    .busy       (busy),
    .done       (done)
  );

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; start = 1'b0; load_val = 4'd0; prescale = 4'd0;
    auto_reload = 1'b0; pause = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; start = 1'b1; load_val = 4'd9; prescale = 4'd3; auto_reload = 1'b1;
    step();
    total++;
    if (q !== 4'd0 || start_ack !== 1'b0 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset q=%0d ack=%b tc=%b busy=%b done=%b, want all 0",
               q, start_ack, tc, busy, done);
    end
    idle_inputs();
    step();
    total++;
    if (q !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || start_ack !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle q=%0d busy=%b done=%b ack=%b, want 0 0 0 0",
               q, busy, done, start_ack);
    end
  endtask

  task automatic test_oneshot();
    logic [3:0] exp_q [6] = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    idle_inputs();
    load_val = 4'd5; start = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      start = 1'b0;
      total++;
      if (q !== exp_q[c] || tc !== (c == 5) || start_ack !== (c == 0)) begin
        bad++;
        $display("FAIL oneshot c%0d q=%0d tc=%b ack=%b, want q=%0d tc=%b ack=%b",
                 c, q, tc, start_ack, exp_q[c], (c == 5), (c == 0));
      end
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL oneshot_end done=%b busy=%b, want 1 0", done, busy);
    end
    step();
    total++;
    if (tc !== 1'b0 || done !== 1'b1 || q !== 4'd0) begin
      bad++;
      $display("FAIL oneshot_hold tc=%b done=%b q=%0d, want 0 1 0", tc, done, q);
    end
  endtask

  task automatic test_autoreload();
    logic [3:0] exp_q;
    logic       exp_tc;
    idle_inputs();
    load_val = 4'd3; prescale = 4'd2; auto_reload = 1'b1; start = 1'b1;
    for (int c = 0; c <= 27; c++) begin
      step();
      start = 1'b0;
      exp_q  = 4'(3 - (c / 3) % 3);
      exp_tc = (c > 0) && (c % 9 == 0);
      total++;
      if (q !== exp_q || tc !== exp_tc || done !== 1'b0 || busy !== 1'b1 ||
          start_ack !== (c == 0)) begin
        bad++;
        $display("FAIL autoreload c%0d q=%0d tc=%b done=%b busy=%b ack=%b, want q=%0d tc=%b",
                 c, q, tc, done, busy, start_ack, exp_q, exp_tc);
      end
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++;
    if (q !== 4'd0 || busy !== 1'b0 || tc !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort_run q=%0d busy=%b tc=%b done=%b, want all 0", q, busy, tc, done);
    end
  endtask

  task automatic test_pause();
    int tc_cyc;
    tc_cyc = -1;
    idle_inputs();
    load_val = 4'd5; prescale = 4'd2; start = 1'b1;
    // Unpaused, tc lands 15 clocks after acceptance; four paused cycles push it to 19.
    for (int c = 0; c <= 40 && tc_cyc < 0; c++) begin
      pause = (c >= 5 && c <= 8);
      step();
      start = 1'b0;
      if (c >= 5 && c <= 8) begin
        total++;
        if (q !== 4'd4 || dut.pre_cnt_q !== 4'd1 || busy !== 1'b1 || tc !== 1'b0) begin
          bad++;
          $display("FAIL pause_freeze c%0d q=%0d pre=%0d busy=%b tc=%b, want 4 1 1 0",
                   c, q, dut.pre_cnt_q, busy, tc);
        end
      end
      if (tc === 1'b1) tc_cyc = c;
    end
    pause = 1'b0;
    total++;
    if (tc_cyc != 19 || done !== 1'b1 || q !== 4'd0) begin
      bad++;
      $display("FAIL pause_len tc_at=%0d done=%b q=%0d, want 19 1 0", tc_cyc, done, q);
    end
  endtask

  task automatic test_abort();
    idle_inputs();
    // Abort while paused.
    load_val = 4'd7; prescale = 4'd3; start = 1'b1;
    step();
    start = 1'b0; pause = 1'b1;
    step();
    step();
    total++;
    if (q !== 4'd7 || busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre q=%0d busy=%b, want 7 1", q, busy);
    end
    abort = 1'b1;
    step();
    abort = 1'b0; pause = 1'b0;
    total++;
    if (q !== 4'd0 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || start_ack !== 1'b0) begin
      bad++;
      $display("FAIL abort_pause q=%0d tc=%b busy=%b done=%b ack=%b, want all 0",
               q, tc, busy, done, start_ack);
    end
    // Abort in DONE.
    load_val = 4'd1; prescale = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    total++;
    if (done !== 1'b1 || tc !== 1'b0 || q !== 4'd0) begin
      bad++;
      $display("FAIL abort_predone done=%b tc=%b q=%0d, want 1 0 0", done, tc, q);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || q !== 4'd0 || tc !== 1'b0) begin
      bad++;
      $display("FAIL abort_done done=%b busy=%b q=%0d tc=%b, want all 0", done, busy, q, tc);
    end
    // Abort together with start in IDLE.
    load_val = 4'd5; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    total++;
    if (start_ack !== 1'b0 || busy !== 1'b0 || q !== 4'd0) begin
      bad++;
      $display("FAIL abort_start_idle ack=%b busy=%b q=%0d, want 0 0 0", start_ack, busy, q);
    end
    step();
    total++;
    if (start_ack !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort_start_after ack=%b busy=%b done=%b, want 0 0 0",
               start_ack, busy, done);
    end
    // Abort together with start in DONE.
    load_val = 4'd0; start = 1'b1;
    step();
    load_val = 4'd6; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    total++;
    if (start_ack !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || q !== 4'd0) begin
      bad++;
      $display("FAIL abort_start_done ack=%b done=%b busy=%b q=%0d, want 0 0 0 0",
               start_ack, done, busy, q);
    end
  endtask

  task automatic test_zero_load();
    idle_inputs();
    load_val = 4'd0; prescale = 4'd5; start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (done !== 1'b1 || tc !== 1'b1 || busy !== 1'b0 || start_ack !== 1'b1 || q !== 4'd0) begin
      bad++;
      $display("FAIL zero_load done=%b tc=%b busy=%b ack=%b q=%0d, want 1 1 0 1 0",
               done, tc, busy, start_ack, q);
    end
    step();
    total++;
    if (tc !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || start_ack !== 1'b0) begin
      bad++;
      $display("FAIL zero_load_hold tc=%b done=%b busy=%b ack=%b, want 0 1 0 0",
               tc, done, busy, start_ack);
    end
  endtask

  task automatic test_reset_mid_run();
    int errs;
    idle_inputs();
    load_val = 4'd7; prescale = 4'd3; auto_reload = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    total++;
    if (q !== 4'd7 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_run_pre q=%0d busy=%b, want 7 1", q, busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (q !== 4'd0 || start_ack !== 1'b0 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL rst_run q=%0d ack=%b tc=%b busy=%b done=%b, want all 0",
               q, start_ack, tc, busy, done);
    end
    errs = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (q !== 4'd0 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL rst_run_quiet bad_cycles=%0d, want 0", errs);
    end
  endtask

  task automatic test_start_in_run();
    logic [3:0] exp_q;
    idle_inputs();
    load_val = 4'd4; prescale = 4'd1; start = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      start = (c == 0) || (c == 2) || (c == 3);
      if (c == 2) begin
        load_val = 4'd9; prescale = 4'd0; auto_reload = 1'b1;
      end
      step();
      exp_q = 4'(4 - c / 2);
      total++;
      if (q !== exp_q || start_ack !== (c == 0) || tc !== (c == 8)) begin
        bad++;
        $display("FAIL start_in_run c%0d q=%0d ack=%b tc=%b, want q=%0d ack=%b tc=%b",
                 c, q, start_ack, tc, exp_q, (c == 0), (c == 8));
      end
    end
    start = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_q    [5] = '{4'd2, 4'd1, 4'd0, 4'd1, 4'd0};
    logic       exp_ack  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       exp_tc   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       exp_done [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    idle_inputs();
    for (int c = 0; c < 5; c++) begin
      start    = (c == 0) || (c == 3);
      load_val = (c == 3) ? 4'd1 : 4'd2;
      step();
      total++;
      if (q !== exp_q[c] || start_ack !== exp_ack[c] || tc !== exp_tc[c] ||
          done !== exp_done[c] || busy !== !exp_done[c]) begin
        bad++;
        $display("FAIL b2b c%0d q=%0d ack=%b tc=%b done=%b busy=%b, want q=%0d ack=%b tc=%b done=%b",
                 c, q, start_ack, tc, done, busy, exp_q[c], exp_ack[c], exp_tc[c], exp_done[c]);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_pause();
    test_abort();
    test_zero_load();
    test_reset_mid_run();
    test_start_in_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
